instr_fetch_unit: RTL and testbench

- Instruction fetch stage: the producer side of the fetch-to-decoder interface.
- Issues halfword reads to instruction memory from a program counter and buffers the returned halfwords.
- Assembles 16-bit and 32-bit instructions and presents them to sixteenbitdecoder-class consumers over a valid/ready handshake.
- Handles control-flow redirects from the execute stage by flushing the buffer and discarding any in-flight response.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_halfword_fifo.sv | 61 ++++++
 rtl/instr_fetch_unit.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: halfword type, request-side
// state encoding and the assembled instruction word layout.
package fetch_pkg;

   localparam int unsigned HW_W        = 16;
   localparam int unsigned INSTR32_BIT = 15;

   typedef logic [HW_W-1:0] halfword_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } req_state_e;

   typedef struct packed {
      halfword_t hi;
      halfword_t lo;
   } instr_word_t;

   // A set bit 15 in the first halfword marks a 32-bit instruction.
   function automatic logic is_instr32(input halfword_t hw);
      return hw[INSTR32_BIT];
   endfunction

endpackage

// File: rtl/fetch_halfword_fifo.sv
// Halfword buffer between memory responses and instruction assembly.
// Single push, pop of one or two entries, synchronous clear for redirects.
module fetch_halfword_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 4,
   localparam int unsigned CNT_W    = $clog2(BUF_DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             push,
   input  halfword_t        push_data,
   input  logic             pop_one,
   input  logic             pop_two,
   output logic [CNT_W-1:0] count,
   output halfword_t        head,
   output halfword_t        head_next
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

   halfword_t        store [BUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [1:0]       pop_n;

   assign pop_n     = {pop_two, pop_one && !pop_two};
   assign head      = store[rd_ptr];
   assign head_next = store[rd_ptr + PTR_W'(1)];

   // Pointer and occupancy update; clear takes priority over push/pop.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr + PTR_W'(pop_n);
         count  <= count + CNT_W'(push) - CNT_W'(pop_n);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            store[i] <= '0;
         end
      end else if (push && !clear) begin
         store[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: halfword memory reads, 16/32-bit assembly, redirects.
// Optional build macro FETCH_STALL_COUNT_EN adds the stall_count output.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       BUF_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_word,
   output logic              instr_is32,
   output logic [ADDR_W-1:0] instr_pc,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [31:0]       stall_count
`endif
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

   req_state_e        state_q;
   req_state_e        state_d;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] fetch_pc_d;
   logic [ADDR_W-1:0] instr_pc_q;
   logic [ADDR_W-1:0] instr_pc_d;
   logic              discard_q;
   logic              discard_d;
   logic [CNT_W-1:0]  buf_count;
   logic [CNT_W-1:0]  count_next;
   halfword_t         head_hw;
   halfword_t         next_hw;
   instr_word_t       word_c;
   logic              head_is32;
   logic              outstanding;
   logic              grant;
   logic              push;
   logic              fire;
   logic              pop_one;
   logic              pop_two;
   logic              space_next;

   fetch_halfword_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (branch_valid),
      .push      (push),
      .push_data (mem_rdata),
      .pop_one   (pop_one),
      .pop_two   (pop_two),
      .count     (buf_count),
      .head      (head_hw),
      .head_next (next_hw)
   );

   // Instruction presentation derived from registered buffer state.
   assign head_is32   = is_instr32(head_hw);
   assign instr_valid = head_is32 ? (buf_count >= CNT_W'(2)) : (buf_count >= CNT_W'(1));
   assign fire        = instr_valid && instr_ready;
   assign pop_one     = fire && !head_is32;
   assign pop_two     = fire && head_is32;
   assign instr_is32  = instr_valid && head_is32;
   assign instr_pc    = instr_pc_q;
   assign instr_word  = instr_valid ? word_c : 32'd0;

   always_comb begin
      word_c    = '0;
      word_c.lo = head_hw;
      if (head_is32) begin
         word_c.hi = next_hw;
      end
   end

   assign grant       = mem_req && mem_gnt;
   assign outstanding = (state_q == WAIT);
   assign push        = mem_rvalid && !discard_q;
   assign mem_addr    = fetch_pc_q;

   // Buffer occupancy after this cycle; redirect empties it.
   always_comb begin
      count_next = buf_count;
      if (branch_valid) begin
         count_next = '0;
      end else begin
         count_next = buf_count + CNT_W'(push) - CNT_W'({pop_two, pop_one});
      end
   end

   assign space_next = (count_next < CNT_W'(BUF_DEPTH));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (space_next) state_d = REQ;
         REQ:     if (mem_gnt) state_d = WAIT;
         WAIT:    if (mem_rvalid) state_d = space_next ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req = 1'b0;
      if (state_q == REQ) begin
         mem_req = 1'b1;
      end
   end

   // PC and discard tracking; a redirect overrides grant and handshake updates.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      instr_pc_d = instr_pc_q;
      discard_d  = discard_q;
      if (grant) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      end
      if (pop_two) begin
         instr_pc_d = instr_pc_q + ADDR_W'(2);
      end else if (pop_one) begin
         instr_pc_d = instr_pc_q + ADDR_W'(1);
      end
      if (mem_rvalid) begin
         discard_d = 1'b0;
      end
      if (branch_valid) begin
         fetch_pc_d = branch_target;
         instr_pc_d = branch_target;
         discard_d  = (outstanding && !mem_rvalid) || grant;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc_q <= RESET_PC;
         instr_pc_q <= RESET_PC;
         discard_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         instr_pc_q <= instr_pc_d;
         discard_q  <= discard_d;
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   // Cycles without a presentable instruction, excluding redirect cycles.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count <= 32'd0;
      end else if (!instr_valid && !branch_valid && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural instruction memory.
module tb_instr_fetch_unit;

   logic        clock;
   logic        reset;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_word;
   logic        instr_is32;
   logic [15:0] instr_pc;
   logic        branch_valid;
   logic [15:0] branch_target;
`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif

   logic        reset_b;
   logic        mem_req_b;
   logic [3:0]  mem_addr_b;
   logic        mem_gnt_b;
   logic        mem_rvalid_b;
   logic [15:0] mem_rdata_b;
   logic        instr_valid_b;
   logic        instr_ready_b;
   logic [31:0] instr_word_b;
   logic        instr_is32_b;
   logic [3:0]  instr_pc_b;
   logic        branch_valid_b;
   logic [3:0]  branch_target_b;
`ifdef FETCH_STALL_COUNT_EN
   logic [31:0] stall_count_b;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] mem   [65536];
   logic [15:0] mem_b [16];
   int          rsp_lat = 1;
   bit          pend;
   int          pend_cnt;
   logic [15:0] pend_addr;
   bit          pend_b;
   logic [3:0]  pend_addr_b;

   instr_fetch_unit #(.ADDR_W(16), .BUF_DEPTH(4), .RESET_PC(16'h0010)) dut (
      .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
      .instr_is32(instr_is32), .instr_pc(instr_pc), .branch_valid(branch_valid),
      .branch_target(branch_target)
`ifdef FETCH_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   instr_fetch_unit #(.ADDR_W(4), .BUF_DEPTH(4), .RESET_PC(4'hF)) dut_b (
      .clock(clock), .reset(reset_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
      .mem_gnt(mem_gnt_b), .mem_rvalid(mem_rvalid_b), .mem_rdata(mem_rdata_b),
      .instr_valid(instr_valid_b), .instr_ready(instr_ready_b), .instr_word(instr_word_b),
      .instr_is32(instr_is32_b), .instr_pc(instr_pc_b), .branch_valid(branch_valid_b),
      .branch_target(branch_target_b)
`ifdef FETCH_STALL_COUNT_EN
      , .stall_count(stall_count_b)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Memory: grants immediately, answers rsp_lat cycles after the grant.
   always @(negedge clock) begin
      if (!reset) begin
         pend       = 1'b0;
         mem_rvalid = 1'b0;
         mem_gnt    = 1'b0;
         mem_rdata  = 16'h0;
      end else begin
         mem_rvalid = 1'b0;
         if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem[pend_addr];
               pend       = 1'b0;
            end
         end
         mem_gnt = mem_req;
         if (mem_gnt) begin
            pend      = 1'b1;
            pend_cnt  = rsp_lat;
            pend_addr = mem_addr;
         end
      end
   end

   always @(negedge clock) begin
      if (!reset_b) begin
         pend_b       = 1'b0;
         mem_rvalid_b = 1'b0;
         mem_gnt_b    = 1'b0;
         mem_rdata_b  = 16'h0;
      end else begin
         mem_rvalid_b = pend_b;
         if (pend_b) mem_rdata_b = mem_b[pend_addr_b];
         pend_b    = 1'b0;
         mem_gnt_b = mem_req_b;
         if (mem_gnt_b) begin
            pend_b      = 1'b1;
            pend_addr_b = mem_addr_b;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for instr_valid on the selected instance.
   task automatic wait_valid(input string tag, input bit sel_b);
      int k = 0;
      while (!(sel_b ? instr_valid_b : instr_valid) && k < 50) begin
         tick();
         k++;
      end
      chk(tag, 32'(sel_b ? instr_valid_b : instr_valid), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'((i - 15) & 32'h7FFF);
      mem[0] = 16'h8005;
      mem[1] = 16'h1234;
      mem[2] = 16'h0042;
      for (int i = 0; i < 16; i++) mem_b[i] = 16'h0000;
      mem_b[15] = 16'h8000;
      mem_b[0]  = 16'h00AA;
      mem_b[1]  = 16'h0033;

      reset = 1'b0; reset_b = 1'b0;
      instr_ready = 1'b1; instr_ready_b = 1'b1;
      branch_valid = 1'b0; branch_target = 16'h0;
      branch_valid_b = 1'b0; branch_target_b = 4'h0;
      repeat (3) tick();

      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'h10);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_word", instr_word, 32'd0);
      chk("rst_is32", 32'(instr_is32), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'h10);
`ifdef FETCH_STALL_COUNT_EN
      chk("rst_stall", stall_count, 32'd0);
`endif

      // Sequential 16-bit stream from RESET_PC, including first-fetch latency
      reset = 1'b1;
      tick();
      chk("t1_req_rise", 32'(mem_req), 32'd1);
      chk("t1_req_addr", 32'(mem_addr), 32'h10);
      chk("t1_valid_c1", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_valid_c2", 32'(instr_valid), 32'd0);
      tick();
      chk("t1_valid_c3", 32'(instr_valid), 32'd1);
      chk("t1_pc0", 32'(instr_pc), 32'h10);
      chk("t1_word0", instr_word, 32'h0000_0001);
      chk("t1_is32_0", 32'(instr_is32), 32'd0);
      tick();
      wait_valid("t1_v1", 1'b0);
      chk("t1_pc1", 32'(instr_pc), 32'h11);
      chk("t1_word1", instr_word, 32'h0000_0002);
      tick();
      wait_valid("t1_v2", 1'b0);
      chk("t1_pc2", 32'(instr_pc), 32'h12);
      chk("t1_word2", instr_word, 32'h0000_0003);
      tick();

      // 32-bit instruction at 0x0000
      branch_valid = 1'b1; branch_target = 16'h0000;
      tick();
      branch_valid = 1'b0;
      chk("t2_valid_after_redirect", 32'(instr_valid), 32'd0);
      wait_valid("t2_v0", 1'b0);
      chk("t2_pc0", 32'(instr_pc), 32'h0);
      chk("t2_is32", 32'(instr_is32), 32'd1);
      chk("t2_word0", instr_word, 32'h1234_8005);
      tick();
      wait_valid("t2_v1", 1'b0);
      chk("t2_pc1", 32'(instr_pc), 32'h2);
      chk("t2_is32_1", 32'(instr_is32), 32'd0);
      chk("t2_word1", instr_word, 32'h0000_0042);
      tick();

      // Back-pressure: buffer fills, requests stop, outputs hold, then drain
      instr_ready = 1'b0;
      branch_valid = 1'b1; branch_target = 16'h0020;
      tick();
      branch_valid = 1'b0;
      repeat (9) tick();
      chk("t3_word_mid", instr_word, 32'h0000_0011);
      chk("t3_pc_mid", 32'(instr_pc), 32'h20);
      repeat (11) tick();
      chk("t3_req_full", 32'(mem_req), 32'd0);
      chk("t3_valid_hold", 32'(instr_valid), 32'd1);
      chk("t3_pc_hold", 32'(instr_pc), 32'h20);
      chk("t3_word_hold", instr_word, 32'h0000_0011);
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_drain_valid%0d", i), 32'(instr_valid), 32'd1);
         chk($sformatf("t3_drain_pc%0d", i), 32'(instr_pc), 32'h20 + 32'(i));
         chk($sformatf("t3_drain_word%0d", i), instr_word, 32'h11 + 32'(i));
         tick();
      end
      wait_valid("t3_v4", 1'b0);
      chk("t3_pc4", 32'(instr_pc), 32'h24);
      chk("t3_word4", instr_word, 32'h0000_0015);
      tick();

      // Redirect with a response in flight: the stale halfword must be dropped
      rsp_lat = 4;
      branch_valid = 1'b1; branch_target = 16'h0030;
      tick();
      branch_valid = 1'b0;
      begin
         int k = 0;
         while (!mem_req && k < 20) begin
            tick();
            k++;
         end
      end
      chk("t4_req_seen", 32'(mem_req), 32'd1);
      tick();
      chk("t4_outstanding", 32'(mem_req), 32'd0);
      branch_valid = 1'b1; branch_target = 16'h0100;
      tick();
      branch_valid = 1'b0;
      rsp_lat = 1;
      chk("t4_valid_after_redirect", 32'(instr_valid), 32'd0);
      wait_valid("t4_v0", 1'b0);
      chk("t4_pc0", 32'(instr_pc), 32'h100);
      chk("t4_word0", instr_word, 32'h0000_00F1);
      tick();
      wait_valid("t4_v1", 1'b0);
      chk("t4_pc1", 32'(instr_pc), 32'h101);
      chk("t4_word1", instr_word, 32'h0000_00F2);
      tick();

      // Reset asserted during WAIT with three halfwords buffered
      instr_ready = 1'b0;
      repeat (20) tick();
      chk("t6_quiet", 32'(mem_req), 32'd0);
      branch_valid = 1'b1; branch_target = 16'h0040;
      tick();
      branch_valid = 1'b0;
      repeat (6) tick();
      chk("t6_req_r7", 32'(mem_req), 32'd1);
      tick();
      chk("t6_wait_r8", 32'(mem_req), 32'd0);
      chk("t6_valid_pre", 32'(instr_valid), 32'd1);
      chk("t6_pc_pre", 32'(instr_pc), 32'h40);
      chk("t6_word_pre", instr_word, 32'h0000_0031);
      reset = 1'b0;
      #1;
      chk("t6_rst_req", 32'(mem_req), 32'd0);
      chk("t6_rst_valid", 32'(instr_valid), 32'd0);
      chk("t6_rst_word", instr_word, 32'd0);
      chk("t6_rst_pc", 32'(instr_pc), 32'h10);
      tick();
      tick();
      reset = 1'b1;
      instr_ready = 1'b1;
      tick();
      chk("t6_restart_req", 32'(mem_req), 32'd1);
      chk("t6_restart_addr", 32'(mem_addr), 32'h10);
      wait_valid("t6_v0", 1'b0);
      chk("t6_pc0", 32'(instr_pc), 32'h10);
      chk("t6_word0", instr_word, 32'h0000_0001);
      tick();

      // 4-bit PC: 32-bit instruction straddling the address wrap
      chk("t5_rst_pc", 32'(instr_pc_b), 32'hF);
      chk("t5_rst_addr", 32'(mem_addr_b), 32'hF);
      reset_b = 1'b1;
      tick();
      wait_valid("t5_v0", 1'b1);
      chk("t5_pc0", 32'(instr_pc_b), 32'hF);
      chk("t5_is32", 32'(instr_is32_b), 32'd1);
      chk("t5_word0", instr_word_b, 32'h00AA_8000);
      tick();
      wait_valid("t5_v1", 1'b1);
      chk("t5_pc1", 32'(instr_pc_b), 32'h1);
      chk("t5_word1", instr_word_b, 32'h0000_0033);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
